// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory responder: default widths,
// wait-state limit and the responder's FSM state encoding.
package mips_mem_pkg;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_WAIT_CYCLES = 2;

    // Largest programmable number of wait states; sizes the wait counter.
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mips_mem_array.sv
// Byte-wide single-port RAM: synchronous write, registered read.
// The read register only updates on a read enable, so it holds the last
// value read while writes proceed.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write and registered read on the same address port.
    // NOTE: the storage array and its read register have no reset; contents
    // must survive a responder reset, and a reset would also stop the array
    // from mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the 8-bit MIPS core. Accepts one read or write
// request, inserts WAIT_CYCLES wait states, performs the access on the
// internal array and pulses ready for one cycle. Both request lines high in
// IDLE is a protocol violation and pulses err instead.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] memdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    // Reject wait-state counts the counter cannot hold.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
        $error("mips_mem_responder: WAIT_CYCLES must be in 0..%0d", MAX_WAIT);
    end

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] adr_q,      adr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              ready_q,    ready_d;
    logic              busy_q,     busy_d;
    logic              err_q,      err_d;
    // Set once a read has completed since reset; gates the RAM read register
    // so memdata reads zero after reset even though the RAM is not reset.
    logic              rd_valid_q, rd_valid_d;

    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] rd_data;

    // State, counter, request latches and registered status outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Next-state, counter and array-strobe decode.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        busy_d     = busy_q;
        err_d      = 1'b0;
        rd_valid_d = rd_valid_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (memread && memwrite) begin
                    err_d = 1'b1;
                end else if (memread || memwrite) begin
                    is_write_d = memwrite;
                    adr_d      = adr;
                    wdata_d    = writedata;
                    cnt_d      = WAIT_CNT;
                    busy_d     = 1'b1;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_we  = is_write_q;
                    mem_re  = !is_write_q;
                    ready_d = 1'b1;
                    state_d = ST_RESP;
                    if (!is_write_q) begin
                        rd_valid_d = 1'b1;
                    end
                end
            end

            // Ready cycle: requests still held here are deliberately ignored.
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    mips_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (adr_q),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

    // Outputs come straight from registers; no input reaches them combinationally.
    assign memdata = rd_valid_q ? rd_data : '0;
    assign ready   = ready_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule
